// File: rtl/mbist_march_engine_if.sv
// Controller handshake and shared memory port of the March C- engine.
// The engine is the slave on the controller side and drives the memory port.
interface mbist_march_engine_if #(
    parameter int NUM_MEM = 9,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
);
    logic               mbist_rst;
    logic               mbist_test;
    logic [NUM_MEM-1:0] mbist_done;
    logic [NUM_MEM-1:0] mbist_fail;
    logic [SEL_W-1:0]   mem_sel;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  mbist_rst, mbist_test, mem_rdata,
        output mbist_done, mbist_fail, mem_sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output mbist_rst, mbist_test, mem_rdata,
        input  mbist_done, mbist_fail, mem_sel, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mbist_march_engine.sv
// March C- engine: tests NUM_MEM single-port memories in turn through one port
// and reports per-memory done and sticky fail flags.
module mbist_march_engine #(
    parameter int NUM_MEM = 9,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    mbist_march_engine_if.slave  bus
);
    localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_MEM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5, DRAIN} elem_t;

    state_t             state, state_nx;
    elem_t              elem, elem_nx;
    logic [ADDR_W-1:0]  addr, addr_nx;
    logic               phase, phase_nx;
    logic               cmp_pend, cmp_pend_nx;
    logic [SEL_W-1:0]   sel, sel_nx;
    logic [NUM_MEM-1:0] done, done_nx;
    logic [NUM_MEM-1:0] fail, fail_nx;

    logic [NUM_MEM-1:0] sel_mask;
    logic               rmw, down, rd_bg, wr_bg, running, cmp_now, mismatch;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            elem     <= M0;
            addr     <= '0;
            phase    <= 1'b0;
            cmp_pend <= 1'b0;
            sel      <= '0;
            done     <= '0;
            fail     <= '0;
        end else begin
            state    <= state_nx;
            elem     <= elem_nx;
            addr     <= addr_nx;
            phase    <= phase_nx;
            cmp_pend <= cmp_pend_nx;
            sel      <= sel_nx;
            done     <= done_nx;
            fail     <= fail_nx;
        end
    end

    // Element decode: M1..M4 are read-then-write pairs; phase 1 is the write half.
    assign rmw      = (elem == M1) || (elem == M2) || (elem == M3) || (elem == M4);
    assign down     = (elem == M3) || (elem == M4);
    assign rd_bg    = (elem == M2) || (elem == M4);
    assign wr_bg    = (elem == M1) || (elem == M3);
    assign running  = (state == RUN);
    assign sel_mask = NUM_MEM'(1) << sel;

    // Read data arrives one cycle after the read: compare in the write half or
    // in the cycle after an M5 read (including the drain cycle).
    assign cmp_now  = running && ((rmw && phase) || cmp_pend);
    assign mismatch = (bus.mem_rdata != {DATA_W{rd_bg}});

    assign bus.mem_en     = running && (elem != DRAIN);
    assign bus.mem_we     = running && ((elem == M0) || (rmw && phase));
    assign bus.mem_wdata  = {DATA_W{bus.mem_we && wr_bg}};
    assign bus.mem_addr   = addr;
    assign bus.mem_sel    = sel;
    assign bus.mbist_done = done;
    assign bus.mbist_fail = fail;

    always_comb begin
        state_nx    = state;
        elem_nx     = elem;
        addr_nx     = addr;
        phase_nx    = phase;
        cmp_pend_nx = 1'b0;
        sel_nx      = sel;
        done_nx     = done;
        fail_nx     = fail;

        if (bus.mbist_rst) begin
            state_nx = IDLE;
            elem_nx  = M0;
            addr_nx  = '0;
            phase_nx = 1'b0;
            sel_nx   = '0;
            done_nx  = '0;
            fail_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mbist_test) begin
                        state_nx = RUN;
                        elem_nx  = M0;
                        addr_nx  = '0;
                        phase_nx = 1'b0;
                        sel_nx   = '0;
                        done_nx  = '0;
                        fail_nx  = '0;
                    end
                end

                RUN: begin
                    if (!bus.mbist_test) begin
                        state_nx = IDLE;
                    end else begin
                        if (cmp_now && mismatch) begin
                            fail_nx = fail | sel_mask;
                        end
                        case (elem)
                            M0: begin
                                if (addr == ADDR_TOP) begin
                                    elem_nx = M1;
                                    addr_nx = '0;
                                end else begin
                                    addr_nx = addr + 1'b1;
                                end
                            end
                            M1, M2, M3, M4: begin
                                phase_nx = ~phase;
                                if (phase && !down) begin
                                    if (addr == ADDR_TOP) begin
                                        elem_nx = (elem == M1) ? M2 : M3;
                                        addr_nx = (elem == M1) ? '0 : ADDR_TOP;
                                    end else begin
                                        addr_nx = addr + 1'b1;
                                    end
                                end else if (phase) begin
                                    if (addr == '0) begin
                                        elem_nx = (elem == M3) ? M4 : M5;
                                        addr_nx = (elem == M3) ? ADDR_TOP : '0;
                                    end else begin
                                        addr_nx = addr - 1'b1;
                                    end
                                end
                            end
                            M5: begin
                                cmp_pend_nx = 1'b1;
                                if (addr == ADDR_TOP) begin
                                    elem_nx = DRAIN;
                                    addr_nx = '0;
                                end else begin
                                    addr_nx = addr + 1'b1;
                                end
                            end
                            default: begin
                                done_nx  = done | sel_mask;
                                elem_nx  = M0;
                                addr_nx  = '0;
                                phase_nx = 1'b0;
                                if (sel == SEL_LAST) begin
                                    state_nx = DONE;
                                end else begin
                                    sel_nx = sel + 1'b1;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    if (!bus.mbist_test) begin
                        state_nx = IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mbist_march_engine.sv
// Directed bench for the March C- engine with a behavioural memory bank that
// can carry a stuck-at fault (memory 3) or a coupling fault (memory 8).
module tb_mbist_march_engine;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   fault_mode;
    logic [7:0] mem [0:8][0:63];

    mbist_march_engine_if #(.NUM_MEM(9), .ADDR_W(6), .DATA_W(8)) bus ();

    mbist_march_engine #(.NUM_MEM(9), .ADDR_W(6), .DATA_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory bank: registered read data, faults injected per fault_mode.
    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_sel][bus.mem_addr] <= bus.mem_wdata;
                if (fault_mode == 2 && bus.mem_sel == 4'd8 && bus.mem_addr == 6'd10)
                    mem[8][11] <= ~mem[8][11];
            end else if (fault_mode == 1 && bus.mem_sel == 4'd3 && bus.mem_addr == 6'd5) begin
                bus.mem_rdata <= mem[bus.mem_sel][bus.mem_addr] | 8'h01;
            end else begin
                bus.mem_rdata <= mem[bus.mem_sel][bus.mem_addr];
            end
        end
    end

    task automatic start_test();
        @(negedge clock);
        bus.mbist_test = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.mbist_rst = 1'b0;
        bus.mbist_test = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_mem_port got %h want 0",
                     {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel});
        end
        checks++;
        if ({bus.mbist_done, bus.mbist_fail} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %h want 0", {bus.mbist_done, bus.mbist_fail});
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_fault_free();
        int done_at;
        done_at = -1;
        fault_mode = 0;
        start_test();
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel} !== {2'b11, 18'd0}) begin
            errors++;
            $display("[TB] FAIL first_access got %h want %h",
                     {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel}, {2'b11, 18'd0});
        end
        for (int n = 1; n <= 6000 && done_at < 0; n++) begin
            @(posedge clock);
            #1;
            if (n == 64) begin
                checks++;
                if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== 8'b10_000000) begin
                    errors++;
                    $display("[TB] FAIL m1_read got %b want 10000000", {bus.mem_en, bus.mem_we, bus.mem_addr});
                end
            end
            if (n == 65) begin
                checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 6'd0, 8'hFF}) begin
                    errors++;
                    $display("[TB] FAIL m1_write got %h want %h",
                             {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 6'd0, 8'hFF});
                end
            end
            if (n == 640) begin
                checks++;
                if ({bus.mem_en, bus.mem_sel, bus.mbist_done} !== {1'b0, 4'd0, 9'h000}) begin
                    errors++;
                    $display("[TB] FAIL drain_cycle got en=%b sel=%0d done=%h want en=0 sel=0 done=000",
                             bus.mem_en, bus.mem_sel, bus.mbist_done);
                end
            end
            if (n == 641) begin
                checks++;
                if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mbist_done} !==
                    {2'b11, 6'd0, 4'd1, 9'h001}) begin
                    errors++;
                    $display("[TB] FAIL next_memory got sel=%0d addr=%0d done=%h want sel=1 addr=0 done=001",
                             bus.mem_sel, bus.mem_addr, bus.mbist_done);
                end
            end
            if (n == 5768) begin
                checks++;
                if (bus.mbist_done !== 9'h0FF) begin
                    errors++;
                    $display("[TB] FAIL done_before_last got %h want 0ff", bus.mbist_done);
                end
            end
            if (bus.mbist_done === 9'h1FF) done_at = n;
        end
        checks++;
        if (done_at != 5769) begin
            errors++;
            $display("[TB] FAIL done_latency got %0d want 5769", done_at);
        end
        checks++;
        if ({bus.mbist_fail, bus.mem_en, dut.state} !== {9'h000, 1'b0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL done_state got fail=%h en=%b state=%0d want fail=000 en=0 state=2",
                     bus.mbist_fail, bus.mem_en, dut.state);
        end
        @(negedge clock);
        bus.mbist_test = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({dut.state, bus.mbist_done} !== {2'd0, 9'h1FF}) begin
            errors++;
            $display("[TB] FAIL done_to_idle got state=%0d done=%h want state=0 done=1ff",
                     dut.state, bus.mbist_done);
        end
    endtask

    task automatic test_stuck_at();
        int limit;
        fault_mode = 1;
        start_test();
        checks++;
        if (bus.mbist_done !== 9'h000) begin
            errors++;
            $display("[TB] FAIL start_clears_done got %h want 000", bus.mbist_done);
        end
        limit = 0;
        while (bus.mbist_done !== 9'h1FF && limit < 6000) begin
            @(posedge clock);
            #1;
            limit++;
        end
        checks++;
        if ({bus.mbist_done, bus.mbist_fail} !== {9'h1FF, 9'h008}) begin
            errors++;
            $display("[TB] FAIL stuck_at got done=%h fail=%h want done=1ff fail=008",
                     bus.mbist_done, bus.mbist_fail);
        end
        @(negedge clock);
        bus.mbist_test = 1'b0;
        fault_mode = 0;
        @(posedge clock);
    endtask

    task automatic test_abort();
        start_test();
        repeat (1400) @(posedge clock);
        @(negedge clock);
        bus.mbist_test = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({bus.mem_en, dut.state, bus.mbist_done, bus.mbist_fail} !== {1'b0, 2'd0, 9'h003, 9'h000}) begin
            errors++;
            $display("[TB] FAIL abort got en=%b state=%0d done=%h fail=%h want en=0 state=0 done=003 fail=000",
                     bus.mem_en, dut.state, bus.mbist_done, bus.mbist_fail);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.mem_en, bus.mbist_done} !== {1'b0, 9'h003}) begin
            errors++;
            $display("[TB] FAIL abort_hold got en=%b done=%h want en=0 done=003", bus.mem_en, bus.mbist_done);
        end
        start_test();
        checks++;
        if ({bus.mbist_done, bus.mem_sel, bus.mem_en, bus.mem_we, bus.mem_addr} !==
            {9'h000, 4'd0, 2'b11, 6'd0}) begin
            errors++;
            $display("[TB] FAIL restart got done=%h sel=%0d en=%b we=%b addr=%0d want done=000 sel=0 en=1 we=1 addr=0",
                     bus.mbist_done, bus.mem_sel, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
    endtask

    task automatic test_mbist_rst();
        repeat (700) @(posedge clock);
        #1;
        checks++;
        if (bus.mbist_done !== 9'h001) begin
            errors++;
            $display("[TB] FAIL pre_clear_done got %h want 001", bus.mbist_done);
        end
        @(negedge clock);
        bus.mbist_rst = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel,
             bus.mbist_done, bus.mbist_fail, dut.state} !== 40'd0) begin
            errors++;
            $display("[TB] FAIL sync_clear got en=%b sel=%0d addr=%0d done=%h state=%0d want all 0",
                     bus.mem_en, bus.mem_sel, bus.mem_addr, bus.mbist_done, dut.state);
        end
        @(negedge clock);
        bus.mbist_rst = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({dut.state, bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'd1, 2'b11, 6'd0}) begin
            errors++;
            $display("[TB] FAIL clear_restart got state=%0d en=%b addr=%0d want state=1 en=1 addr=0",
                     dut.state, bus.mem_en, bus.mem_addr);
        end
    endtask

    task automatic test_async_reset();
        repeat (700) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mbist_done, bus.mbist_fail} !== 30'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got en=%b sel=%0d addr=%0d done=%h want all 0",
                     bus.mem_en, bus.mem_sel, bus.mem_addr, bus.mbist_done);
        end
        bus.mbist_test = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({dut.state, bus.mem_en} !== {2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release got state=%0d en=%b want state=0 en=0", dut.state, bus.mem_en);
        end
    endtask

    task automatic test_coupling();
        int seq_err;
        int limit;
        int j;
        seq_err = 0;
        fault_mode = 2;
        start_test();
        limit = 0;
        for (int n = 1; n <= 6000 && bus.mbist_done !== 9'h1FF; n++) begin
            @(posedge clock);
            #1;
            limit = n;
            if (n >= 5448 && n < 5448 + 128) begin
                j = (n - 5448) / 2;
                if (bus.mem_sel !== 4'd8 || bus.mem_en !== 1'b1 || bus.mem_addr !== 6'(63 - j) ||
                    bus.mem_we !== 1'(((n - 5448) % 2)))
                    seq_err++;
            end
        end
        checks++;
        if (seq_err != 0) begin
            errors++;
            $display("[TB] FAIL m3_sequence got %0d bad cycles want 0", seq_err);
        end
        checks++;
        if ({bus.mbist_done, bus.mbist_fail, limit} !== {9'h1FF, 9'h100, 32'd5769}) begin
            errors++;
            $display("[TB] FAIL coupling got done=%h fail=%h cycles=%0d want done=1ff fail=100 cycles=5769",
                     bus.mbist_done, bus.mbist_fail, limit);
        end
        @(negedge clock);
        bus.mbist_test = 1'b0;
        fault_mode = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fault_mode = 0;
        bus.mem_rdata = 8'h00;
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_abort();
        test_mbist_rst();
        test_async_reset();
        test_coupling();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
